// File: rtl/byte_serial_adder_pkg.sv
// Shared constants for the byte-serial wide adder: FSM encodings, lane width,
// and the lane-index width helper.
package byte_serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int LANE_W = 8;

  // ceil(log2(n)); legal n is 2..16, so the result is always at least 1
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/carry_select_8b_adder.sv
// Existing 8-bit carry-select adder: low nibble ripples, high nibble is
// precomputed for both carry-in values and picked by the low nibble carry.
module carry_select_8b_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  // both high-nibble candidates computed in parallel with the low nibble
  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
    s    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    cout = lo[4] ? hi1[4] : hi0[4];
  end

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial wide adder: feeds one 8-bit lane per clock, LSB first, through a
// single carry_select_8b_adder with the carry registered between lanes.
// Optional signed-overflow output enabled by BYTE_SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one lane added per cycle, idx selects the lane
// DONE  | out_valid high, result held until out_ready
module byte_serial_adder
  import byte_serial_adder_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANE_W*N_BYTES-1:0]   a,
  input  logic [LANE_W*N_BYTES-1:0]   b,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANE_W*N_BYTES-1:0]   sum,
  output logic                        cout,
  output logic                        busy
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  ,
  output logic                        ovf
`endif
);

  localparam int W     = LANE_W * N_BYTES;
  localparam int IDX_W = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BYTES - 1);

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              carry_q;

  logic [LANE_W-1:0] lane_a;
  logic [LANE_W-1:0] lane_b;
  logic [LANE_W-1:0] lane_s;
  logic              lane_cout;

  // handshake and status flags decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    lane_a    = a_q[LANE_W*idx +: LANE_W];
    lane_b    = b_q[LANE_W*idx +: LANE_W];
  end

  carry_select_8b_adder u_lane_adder (
    .a    (lane_a),
    .b    (lane_b),
    .cin  (carry_q),
    .s    (lane_s),
    .cout (lane_cout)
  );

  // sequencing FSM, operand capture and lane-by-lane result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[LANE_W*idx +: LANE_W] <= lane_s;
          carry_q                   <= lane_cout;
          if (idx == LAST) begin
            cout  <= lane_cout;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BYTE_SERIAL_ADDER_OVF_EN
  // carry into the sign bit is recovered from the top lane's sign-bit inputs and sum
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && idx == LAST) begin
      ovf <= lane_cout ^ (a_q[W-1] ^ b_q[W-1] ^ lane_s[LANE_W-1]);
    end
  end
`endif

endmodule

// File: tb/tb_byte_serial_adder.sv
// Directed self-checking bench for byte_serial_adder at N_BYTES=4.
module tb_byte_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        busy;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  logic        ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  byte_serial_adder #(.N_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one operand pair, wait for out_valid, check, optionally hold, then drain.
  // Called at #1 after a rising edge.
  task automatic run_op(input vec_t v, input int hold);
    int cycles;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    cycles   = 0;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("latency", 64'(cycles), 64'd4);
    chk("sum", 64'(sum), 64'(v.exp_sum));
    chk("cout", 64'(cout), 64'(v.exp_cout));
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    chk("ovf", 64'(ovf), 64'(v.exp_ovf));
`endif
    chk("in_ready_done", 64'(in_ready), 64'd0);
    chk("busy_done", 64'(busy), 64'd1);
    if (hold > 0) begin
      a        = 32'h0101_0101;
      b        = 32'h0202_0202;
      cin      = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_sum", 64'(sum), 64'(v.exp_sum));
        chk("hold_cout", 64'(cout), 64'(v.exp_cout));
        chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    chk("drain_busy", 64'(busy), 64'd0);
    chk("idle_sum_kept", 64'(sum), 64'(v.exp_sum));
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[2] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    // reset with in_valid asserted at the same time: must not be accepted
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 32'h0000_0011;
    b         = 32'h0000_0022;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(posedge clk);
    #1;
    chk("idle_stays", 64'(busy), 64'd0);

    for (int i = 0; i < 8; i++) run_op(vecs[i], 0);

    // all-ones with cin, result held for five cycles while a new offer is ignored
    run_op('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0}, 5);

    // abort mid-RUN: reset after idx has advanced to 2
    a        = 32'h1111_1111;
    b        = 32'h2222_2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_run_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    run_op('{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
